// File: rtl/alu_cmd_sequencer.sv
// Command front end for the 16-bit ALU: queues tagged commands, drives registered ALU inputs,
// and returns captured results with status over a valid/ready response channel.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_chain,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [2:0]       alu_op,
  input  logic [15:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_illegal,
  output logic             busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic [15:0]       fa_q [DEPTH];
  logic [15:0]       fa_d [DEPTH];
  logic [15:0]       fb_q [DEPTH];
  logic [15:0]       fb_d [DEPTH];
  logic [2:0]        fop_q [DEPTH];
  logic [2:0]        fop_d [DEPTH];
  logic              fchain_q [DEPTH];
  logic              fchain_d [DEPTH];
  logic [TAG_W-1:0]  ftag_q [DEPTH];
  logic [TAG_W-1:0]  ftag_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d, pend_op_q, pend_op_d;
  logic [TAG_W-1:0]  pend_tag_q, pend_tag_d, rsp_tag_q, rsp_tag_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [15:0]       rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d, rsp_neg_q, rsp_neg_d, rsp_ill_q, rsp_ill_d;
  logic              full, empty, push, issue;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  // Readiness depends only on the registered count, so a same-cycle pop never frees a slot.
  assign push  = cmd_valid && !full;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    pend_op_d   = pend_op_q;
    pend_tag_d  = pend_tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_neg_d   = rsp_neg_q;
    rsp_ill_d   = rsp_ill_q;
    issue       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          issue   = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        rsp_data_d  = alu_result;
        acc_d       = alu_result;
        rsp_tag_d   = pend_tag_q;
        rsp_zero_d  = (alu_result == 16'h0000);
        rsp_neg_d   = alu_result[15] && (pend_op_q[2:1] == 2'b00);
        rsp_ill_d   = (pend_op_q[2:1] == 2'b11);
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!empty) begin
            issue   = 1'b1;
            state_d = StExec;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Chain is resolved here, at issue, so it sees the result of the previous command.
    if (issue) begin
      alu_a_d    = fchain_q[rd_ptr_q] ? acc_q : fa_q[rd_ptr_q];
      alu_b_d    = fb_q[rd_ptr_q];
      alu_op_d   = fop_q[rd_ptr_q];
      pend_op_d  = fop_q[rd_ptr_q];
      pend_tag_d = ftag_q[rd_ptr_q];
    end
  end

  always_comb begin
    fa_d     = fa_q;
    fb_d     = fb_q;
    fop_d    = fop_q;
    fchain_d = fchain_q;
    ftag_d   = ftag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fa_d[wr_ptr_q]     = cmd_a;
      fb_d[wr_ptr_q]     = cmd_b;
      fop_d[wr_ptr_q]    = cmd_op;
      fchain_d[wr_ptr_q] = cmd_chain;
      ftag_d[wr_ptr_q]   = cmd_tag;
      wr_ptr_d           = wr_ptr_q + PtrW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push) - CntW'(issue);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      acc_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      pend_op_q   <= '0;
      pend_tag_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_neg_q   <= 1'b0;
      rsp_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      pend_op_q   <= pend_op_d;
      pend_tag_q  <= pend_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_neg_q   <= rsp_neg_d;
      rsp_ill_q   <= rsp_ill_d;
    end
  end

  // Entry storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    fa_q     <= fa_d;
    fb_q     <= fb_d;
    fop_q    <= fop_d;
    fchain_q <= fchain_d;
    ftag_q   <= ftag_d;
  end

  assign cmd_ready   = !full;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_neg     = rsp_neg_q;
  assign rsp_illegal = rsp_ill_q;
  assign busy        = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: emulates the ALU, keeps an in-order response model with its own
// accumulator, and mixes directed scenarios with a randomized traffic phase.
module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  tag;
    logic        z;
    logic        n;
    logic        il;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_chain;
  logic [15:0] cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_tag;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        rsp_valid, rsp_ready, rsp_zero, rsp_neg, rsp_illegal, busy;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_tag;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        accepted;
  logic [15:0] m_acc;
  rsp_t        exp_q[$];
  int          hs_cyc[$];
  logic [3:0]  hs_tag[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_op(cmd_op), .cmd_chain(cmd_chain), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                            input logic chain, input logic [3:0] tag);
    rsp_t        e;
    logic [15:0] r;
    r      = alu_f(chain ? m_acc : a, b, op);
    m_acc  = r;
    e.d    = r;
    e.tag  = tag;
    e.z    = (r == 16'h0000);
    e.n    = (op <= 3'd1) && r[15];
    e.il   = (op >= 3'd6);
    exp_q.push_back(e);
  endtask

  // One clock: check any presented response at negedge, then update the model at the edge.
  task automatic tick();
    logic        acc_now, hs_now, ch;
    logic [15:0] a, b;
    logic [2:0]  op;
    logic [3:0]  tg, rtag;
    rsp_t        e;
    @(negedge clk);
    acc_now = cmd_valid && cmd_ready && rst_n;
    hs_now  = rsp_valid && rsp_ready && rst_n;
    a = cmd_a; b = cmd_b; op = cmd_op; ch = cmd_chain; tg = cmd_tag; rtag = rsp_tag;
    if (rst_n && rsp_valid) begin
      chk("rsp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_tag", rsp_tag, e.tag);
        chk("rsp_zero", rsp_zero, e.z);
        chk("rsp_neg", rsp_neg, e.n);
        chk("rsp_illegal", rsp_illegal, e.il);
      end
    end
    @(posedge clk);
    cyc++;
    accepted = acc_now;
    if (!rst_n) begin
      exp_q.delete();
      m_acc = 16'h0000;
    end else begin
      if (hs_now && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        hs_cyc.push_back(cyc);
        hs_tag.push_back(rtag);
      end
      if (acc_now) model_push(a, b, op, ch, tg);
    end
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                      input logic chain, input logic [3:0] tag);
    logic got;
    got = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain; cmd_tag = tag; cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      tick();
      got = accepted;
    end
    cmd_valid = 1'b0;
    chk("send_accepted", got, 1);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) tick();
    chk("drain_empty", exp_q.size(), 0);
    tick();
    rsp_ready = 1'b0;
  endtask

  // Single command into an idle sequencer; checks latency and the response fields.
  task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         input logic chain, input logic [3:0] tag, input logic [15:0] d,
                         input logic z, input logic n, input logic il);
    rsp_ready = 1'b0;
    send(a, b, op, chain, tag);
    tick();
    chk("lat_t1_valid", rsp_valid, 0);
    tick();
    chk("lat_t2_valid", rsp_valid, 1);
    chk("dir_data", rsp_data, d);
    chk("dir_tag", rsp_tag, tag);
    chk("dir_zero", rsp_zero, z);
    chk("dir_neg", rsp_neg, n);
    chk("dir_illegal", rsp_illegal, il);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("after_hs_valid", rsp_valid, 0);
    chk("after_hs_busy", busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    int idx;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_chain = 1'b0;
    cmd_tag = '0; rsp_ready = 1'b0; m_acc = 16'h0000; accepted = 1'b0;
    tick();
    do_reset();
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_flags", {rsp_zero, rsp_neg, rsp_illegal}, 0);
    chk("rst_alu", {alu_a, alu_b, 13'(alu_op)}, 0);

    run_cmd(16'h0003, 16'h0004, 3'd0, 1'b0, 4'd1, 16'h0007, 1'b0, 1'b0, 1'b0);
    run_cmd(16'h0001, 16'h0002, 3'd1, 1'b0, 4'd2, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    run_cmd(16'hFFFF, 16'h0000, 3'd2, 1'b0, 4'd3, 16'h0000, 1'b1, 1'b0, 1'b0);

    do_reset();
    run_cmd(16'h4321, 16'h0006, 3'd0, 1'b1, 4'd4, 16'h0006, 1'b0, 1'b0, 1'b0);
    run_cmd(16'h0005, 16'h0003, 3'd0, 1'b0, 4'd5, 16'h0008, 1'b0, 1'b0, 1'b0);
    run_cmd(16'h1234, 16'h0002, 3'd0, 1'b1, 4'd6, 16'h000A, 1'b0, 1'b0, 1'b0);
    run_cmd(16'h1234, 16'h000A, 3'd1, 1'b1, 4'd7, 16'h0000, 1'b1, 1'b0, 1'b0);

    run_cmd(16'hAAAA, 16'h5555, 3'd7, 1'b0, 4'd8, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_cmd(16'h7777, 16'h0001, 3'd0, 1'b1, 4'd9, 16'h0001, 1'b0, 1'b0, 1'b0);

    // Backpressure: DEPTH queued plus one in flight before cmd_ready falls.
    rsp_ready = 1'b0;
    idx = 0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cmd_a = 16'(idx * 5 + 1); cmd_b = 16'(idx); cmd_op = 3'd0; cmd_chain = 1'b0;
      cmd_tag = 4'(idx);
      tick();
      if (accepted) idx++;
    end
    chk("bp_accepted", idx, 5);
    chk("bp_cmd_ready", cmd_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_head_tag", rsp_tag, 0);
    chk("bp_head_data", rsp_data, 16'h0001);
    hs_cyc.delete();
    hs_tag.delete();
    rsp_ready = 1'b1;
    for (int k = 0; k < 40 && idx < 7; k++) begin
      cmd_a = 16'(idx * 5 + 1); cmd_b = 16'(idx); cmd_tag = 4'(idx);
      tick();
      if (accepted) idx++;
    end
    cmd_valid = 1'b0;
    chk("bp_all_accepted", idx, 7);
    drain();
    chk("bp_hs_count", hs_tag.size(), 7);
    for (int i = 0; i < hs_tag.size(); i++) chk("bp_order", hs_tag[i], i);
    for (int i = 0; i < 4 && i + 1 < hs_cyc.size(); i++)
      chk("bp_spacing", hs_cyc[i+1] - hs_cyc[i], 2);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_a     = 16'($urandom);
      cmd_b     = 16'($urandom);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_chain = 1'($urandom_range(0, 1));
      cmd_tag   = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    drain();

    // Reset mid-operation: three queued, one held in the response stage.
    rsp_ready = 1'b0;
    send(16'h0011, 16'h0001, 3'd0, 1'b0, 4'd1);
    send(16'h0022, 16'h0002, 3'd0, 1'b0, 4'd2);
    send(16'h0033, 16'h0003, 3'd3, 1'b0, 4'd3);
    send(16'h0044, 16'h0004, 3'd4, 1'b0, 4'd4);
    chk("mid_busy", busy, 1);
    chk("mid_rsp_valid", rsp_valid, 1);
    chk("mid_cmd_ready", cmd_ready, 1);
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("no_stale_rsp", rsp_valid, 0);
    end
    run_cmd(16'h9999, 16'h0005, 3'd0, 1'b1, 4'd10, 16'h0005, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator-side front end for the 16-bit structural ALU. Accepts tagged ALU commands over a valid/ready channel and buffers them in a small in-order FIFO. Drives the ALU's combinational operand/opcode inputs from registers, captures the result, and returns it with tag and status flags over a valid/ready response channel. Optional chain mode substitutes the previous result for operand A, giving accumulator-style operation.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, >= 2
TAG_W, 4, width of command/response tag

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_a  input  16  operand A
cmd_b  input  16  operand B
cmd_op  input  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not, 11x illegal)
cmd_chain  input  1  1 = use accumulator in place of cmd_a
cmd_tag  input  TAG_W  returned unchanged with the result
alu_a  output  16  to ALU inputA, registered
alu_b  output  16  to ALU inputB, registered
alu_op  output  3  to ALU opcode, registered
alu_result  input  16  from ALU result, combinational from alu_a/alu_b/alu_op
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  16  captured ALU result
rsp_tag  output  TAG_W  tag of the command
rsp_zero  output  1  rsp_data == 0
rsp_neg  output  1  rsp_data[15] for opcodes 000/001; 0 otherwise
rsp_illegal  output  1  opcode was 110 or 111
busy  output  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset: synchronous, when rst_n == 0 at a clk edge. All outputs 0 except cmd_ready. cmd_ready == 1 in the first cycle after reset. FIFO emptied, accumulator = 0, FSM = IDLE. A reset mid-operation discards queued and in-flight commands; no response is produced for them.
- FIFO: push when cmd_valid && cmd_ready. cmd_ready = !full, based on the registered count only. A pop in the same cycle does not free a slot for a push in that cycle. Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Chain resolution: done at issue time, not at push time. The effective A is the accumulator if the entry's chain bit is set, otherwise the entry's A.
- FSM states IDLE, EXEC, RESP:
  - IDLE: if FIFO not empty, load alu_a/alu_b/alu_op and a pending tag/op from the head, pop, go to EXEC. Otherwise stay in IDLE.
  - EXEC (one cycle):
    - capture alu_result into rsp_data and the accumulator
    - set rsp_tag, rsp_zero, rsp_neg, rsp_illegal
    - set rsp_valid = 1 and go to RESP
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On the handshake:
    - if FIFO not empty, issue the head (same actions as IDLE) and go to EXEC; rsp_valid drops to 0 the next cycle
    - otherwise clear rsp_valid and go to IDLE
- alu_a/alu_b/alu_op keep their last issued values when not issuing.
- Latency: a command pushed at edge T into an empty, idle sequencer is issued at T+1, and rsp_valid is high after T+2. Sustained throughput is one command per 2 cycles with rsp_ready tied to 1.
- Capacity: up to DEPTH queued plus 1 in flight. With rsp_ready = 0, DEPTH+1 commands are accepted before cmd_ready falls.
- Illegal opcodes pass through to the ALU, which yields 0. The response gives rsp_data = 0, rsp_zero = 1, rsp_illegal = 1, and the accumulator is updated to 0.
- Arithmetic: add/sub wrap modulo 2^16. No carry or overflow is reported.
- Ordering: responses are strictly in command order.

Test Plan:
- After reset: push ADD a=0x0003 b=0x0004 tag=1 -> rsp_valid high 2 cycles after the push; rsp_data = 0x0007, tag = 1, zero = 0, neg = 0.
- SUB a=0x0001 b=0x0002 -> rsp_data = 0xFFFF, neg = 1, zero = 0. Then AND 0xFFFF & 0x0000 -> rsp_data = 0x0000, zero = 1, neg = 0.
- Chain:
  - ADD 0x0005 + 0x0003 -> 0x0008
  - then chain ADD b = 0x0002 (cmd_a = 0x1234, ignored) -> 0x000A
  - then chain SUB b = 0x000A -> 0x0000, zero = 1
  - separately, a chain command first after reset uses A = 0
- Backpressure: rsp_ready = 0, offer tags 0..6 back-to-back -> exactly 5 accepted, then cmd_ready = 0 and rsp stays stable. Raise rsp_ready -> tags 0..4 return in order, one every 2 cycles. Remaining tags are accepted as slots free.
- Illegal op 3'b111 with a = 0xAAAA -> rsp_data = 0, zero = 1, illegal = 1. A following chain ADD b = 0x0001 -> 0x0001.
- Reset mid-operation: 3 queued plus 1 in RESP, assert rst_n = 0 for one edge -> rsp_valid = 0, busy = 0, cmd_ready = 1. No stale responses appear, and the accumulator reads 0 on the next chain command.
